// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {cs_n,ras_n,cas_n,we_n}, arbiter states, default widths.
package sdram_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int BA_W_DEF   = 2;
  localparam int DATA_W_DEF = 16;

  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
  localparam logic [3:0] CMD_WRITE        = 4'b0100;
  localparam logic [3:0] CMD_READ         = 4'b0101;
  localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_ARBIT = 3'd1;
  localparam logic [2:0] ST_AREF  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;

endpackage

// File: rtl/sdram_arbit.sv
// Grants one sequencer at a time (refresh > write > read) and muxes its command onto the SDRAM pins.
// Latency: grant one cycle after request; pin mux is combinational. Backpressure: none, requests wait in ARBIT until granted.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int BA_W        = BA_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REF_TIMEOUT = 700
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [BA_W-1:0]   init_ba,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              a_ref_req,
  input  logic              a_ref_end,
  input  logic [3:0]        a_ref_cmd,
  input  logic [BA_W-1:0]   a_ref_ba,
  input  logic [ADDR_W-1:0] a_ref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_sdram_en,
  input  logic [DATA_W-1:0] wr_sdram_data,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              a_ref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe,
  output logic              ref_overrun
);

  localparam logic [9:0] REF_LIM = 10'(REF_TIMEOUT);

  logic [2:0]        state, state_nxt;
  logic [3:0]        cmd_sel;
  logic [BA_W-1:0]   ba_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [9:0]        ref_cnt, ref_cnt_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  if (init_end) state_nxt = ST_ARBIT;
      ST_ARBIT: begin
        if (a_ref_req)   state_nxt = ST_AREF;
        else if (wr_req) state_nxt = ST_WRITE;
        else if (rd_req) state_nxt = ST_READ;
      end
      ST_AREF:  if (a_ref_end) state_nxt = ST_ARBIT;
      ST_WRITE: if (wr_end)    state_nxt = ST_ARBIT;
      ST_READ:  if (rd_end)    state_nxt = ST_ARBIT;
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= ST_INIT;
    else         state <= state_nxt;
  end

  assign a_ref_en = (state == ST_AREF);
  assign wr_en    = (state == ST_WRITE);
  assign rd_en    = (state == ST_READ);

  // Pins follow the granted sequencer with no register stage; idle arbitration drives NOP.
  always_comb begin
    cmd_sel  = CMD_NOP;
    ba_sel   = '1;
    addr_sel = '1;
    case (state)
      ST_INIT:  begin cmd_sel = init_cmd;  ba_sel = init_ba;  addr_sel = init_addr;  end
      ST_AREF:  begin cmd_sel = a_ref_cmd; ba_sel = a_ref_ba; addr_sel = a_ref_addr; end
      ST_WRITE: begin cmd_sel = wr_cmd;    ba_sel = wr_ba;    addr_sel = wr_addr;    end
      ST_READ:  begin cmd_sel = rd_cmd;    ba_sel = rd_ba;    addr_sel = rd_addr;    end
      default:  ;
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_sel;
  assign sdram_ba     = ba_sel;
  assign sdram_addr   = addr_sel;
  assign sdram_cke    = ~sys_rst;
  assign sdram_dq_oe  = (state == ST_WRITE) & wr_sdram_en;
  assign sdram_dq_out = sdram_dq_oe ? wr_sdram_data : '0;

  // Watchdog: counts cycles a refresh request waits unserved; overrun is sticky until reset.
  always_comb begin
    ref_cnt_nxt = ref_cnt;
    if (!a_ref_req || state == ST_AREF) ref_cnt_nxt = '0;
    else if (ref_cnt != '1)             ref_cnt_nxt = ref_cnt + 10'd1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ref_cnt     <= '0;
      ref_overrun <= 1'b0;
    end else begin
      ref_cnt <= ref_cnt_nxt;
      if (ref_cnt_nxt == REF_LIM) ref_overrun <= 1'b1;
    end
  end

endmodule
